// File: rtl/decode_cycle.sv
// RV32I decode stage: control decoder, immediate extender, register file with
// write-through bypass, and the ID/EX pipeline register with flush-to-bubble.
module decode_cycle #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      RdE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic            IllegalE
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            alu_src;
        logic [1:0]      result_src;
        logic [2:0]      alu_control;
        logic            illegal;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
    } idex_t;

    logic [XLEN-1:0] regs_q [NREG];
    idex_t           idex_d;
    idex_t           idex_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       wr_en;
    logic [2:0] alu_op_fn;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign Rs1D   = InstrD[19:15];
    assign Rs2D   = InstrD[24:20];
    assign wr_en  = RegWriteW && (RDW != 5'd0);

    // Reset wins over the same-edge writeback, so the whole file clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[RDW] <= ResultW;
        end
    end

    // Shared funct3 decode for R-type and I-ALU; only R-type may select sub.
    always_comb begin
        alu_op_fn = ALU_ADD;
        case (funct3)
            3'b000:  alu_op_fn = (opcode == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op_fn = ALU_SLT;
            3'b110:  alu_op_fn = ALU_OR;
            3'b111:  alu_op_fn = ALU_AND;
            default: alu_op_fn = ALU_ADD;
        endcase
    end

    always_comb begin
        idex_d     = '0;
        idex_d.pc  = PCD;
        idex_d.pc4 = PCPlus4D;
        idex_d.rd  = InstrD[11:7];
        idex_d.rs1 = Rs1D;
        idex_d.rs2 = Rs2D;
        idex_d.rd1 = (Rs1D == 5'd0) ? '0 : ((wr_en && RDW == Rs1D) ? ResultW : regs_q[Rs1D]);
        idex_d.rd2 = (Rs2D == 5'd0) ? '0 : ((wr_en && RDW == Rs2D) ? ResultW : regs_q[Rs2D]);
        case (opcode)
            OP_LW: begin
                idex_d.reg_write  = 1'b1;
                idex_d.alu_src    = 1'b1;
                idex_d.result_src = 2'b01;
                idex_d.imm        = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            end
            OP_SW: begin
                idex_d.mem_write  = 1'b1;
                idex_d.alu_src    = 1'b1;
                idex_d.imm        = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            end
            OP_R: begin
                idex_d.reg_write   = 1'b1;
                idex_d.alu_control = alu_op_fn;
            end
            OP_I: begin
                idex_d.reg_write   = 1'b1;
                idex_d.alu_src     = 1'b1;
                idex_d.alu_control = alu_op_fn;
                idex_d.imm         = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            end
            OP_BEQ: begin
                idex_d.branch      = 1'b1;
                idex_d.alu_control = ALU_SUB;
                idex_d.imm         = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                                      InstrD[11:8], 1'b0};
            end
            OP_JAL: begin
                idex_d.reg_write  = 1'b1;
                idex_d.jump       = 1'b1;
                idex_d.result_src = 2'b10;
                idex_d.imm        = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                                     InstrD[30:21], 1'b0};
            end
            default: idex_d.illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign RegWriteE   = idex_q.reg_write;
    assign MemWriteE   = idex_q.mem_write;
    assign BranchE     = idex_q.branch;
    assign JumpE       = idex_q.jump;
    assign ALUSrcE     = idex_q.alu_src;
    assign ResultSrcE  = idex_q.result_src;
    assign ALUControlE = idex_q.alu_control;
    assign IllegalE    = idex_q.illegal;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc4;
    assign RdE         = idex_q.rd;
    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: the driver queues hand-computed ID/EX
// expectations, the monitor checks them one edge after each issued vector.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
    logic        FlushE = 1'b0, RegWriteW = 1'b0;
    logic [4:0]  RDW = '0;
    logic [4:0]  Rs1D, Rs2D, RdE, Rs1E, Rs2E;
    logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    typedef struct {
        string       name;
        logic        rw, mw, br, jp, as, ill;
        logic [1:0]  rs;
        logic [2:0]  alu;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rd, rs1, rs2;
        logic        chk_imm;
    } exp_t;

    exp_t sb_q[$];

    decode_cycle #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .IllegalE(IllegalE)
    );

    always #5 clk = ~clk;

    function automatic int chk(string tag, string field, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, field, act, exp);
            return 1;
        end
        return 0;
    endfunction

    function automatic exp_t ex(logic rw, mw, br, jp, as, logic [1:0] rs, logic [2:0] alu,
                                logic ill, logic [31:0] rd1, rd2, imm,
                                logic [4:0] rd, rs1, rs2, logic ci);
        exp_t e;
        e.name = ""; e.rw = rw; e.mw = mw; e.br = br; e.jp = jp; e.as = as; e.rs = rs;
        e.alu = alu; e.ill = ill; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
        e.pc = '0; e.pc4 = '0; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.chk_imm = ci;
        return e;
    endfunction

    function automatic exp_t ez();
        return ex(0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    endfunction

    task automatic issue(string name, logic r, logic f, logic [31:0] instr, logic [31:0] pc,
                         logic we, logic [4:0] rdw, logic [31:0] res, exp_t e);
        int unused;
        @(negedge clk);
        rst = r; FlushE = f; InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
        RegWriteW = we; RDW = rdw; ResultW = res;
        e.name = name;
        e.pc   = (r || f) ? 32'd0 : pc;
        e.pc4  = (r || f) ? 32'd0 : pc + 32'd4;
        sb_q.push_back(e);
        #1;
        if (!r && !f) begin
            unused = chk(name, "Rs1D", {27'd0, Rs1D}, {27'd0, e.rs1});
            unused = chk(name, "Rs2D", {27'd0, Rs2D}, {27'd0, e.rs2});
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        int   bad;
        #1;
        if (sb_q.size() != 0) begin
            e   = sb_q.pop_front();
            bad = 0;
            bad += chk(e.name, "RegWriteE",   {31'd0, RegWriteE},   {31'd0, e.rw});
            bad += chk(e.name, "MemWriteE",   {31'd0, MemWriteE},   {31'd0, e.mw});
            bad += chk(e.name, "BranchE",     {31'd0, BranchE},     {31'd0, e.br});
            bad += chk(e.name, "JumpE",       {31'd0, JumpE},       {31'd0, e.jp});
            bad += chk(e.name, "ALUSrcE",     {31'd0, ALUSrcE},     {31'd0, e.as});
            bad += chk(e.name, "ResultSrcE",  {30'd0, ResultSrcE},  {30'd0, e.rs});
            bad += chk(e.name, "ALUControlE", {29'd0, ALUControlE}, {29'd0, e.alu});
            bad += chk(e.name, "IllegalE",    {31'd0, IllegalE},    {31'd0, e.ill});
            bad += chk(e.name, "RD1E",        RD1E,                 e.rd1);
            bad += chk(e.name, "RD2E",        RD2E,                 e.rd2);
            if (e.chk_imm) bad += chk(e.name, "ImmExtE", ImmExtE, e.imm);
            bad += chk(e.name, "PCE",         PCE,                  e.pc);
            bad += chk(e.name, "PCPlus4E",    PCPlus4E,             e.pc4);
            bad += chk(e.name, "RdE",         {27'd0, RdE},         {27'd0, e.rd});
            bad += chk(e.name, "Rs1E",        {27'd0, Rs1E},        {27'd0, e.rs1});
            bad += chk(e.name, "Rs2E",        {27'd0, Rs2E},        {27'd0, e.rs2});
            $display("txn %0d %s: field errors=%0d", txn, e.name, bad);
            txn++;
        end
    end

    initial begin
        int unused;
        issue("rst0", 1, 0, 32'h00500093, 32'h00, 0, 5'd0, 32'h0, ez());
        issue("rst1", 1, 0, 32'h00500093, 32'h00, 0, 5'd0, 32'h0, ez());
        issue("addi", 0, 0, 32'h00500093, 32'h10, 1, 5'd1, 32'h5,
              ex(1, 0, 0, 0, 1, 2'd0, 3'd0, 0, 32'h0, 32'h0, 32'h5, 5'd1, 5'd0, 5'd5, 1));
        issue("sub", 0, 0, 32'h40118233, 32'h14, 1, 5'd2, 32'h1234,
              ex(1, 0, 0, 0, 0, 2'd0, 3'd1, 0, 32'h0, 32'h5, 32'h0, 5'd4, 5'd3, 5'd1, 1));
        issue("add", 0, 0, 32'h002081B3, 32'h18, 1, 5'd5, 32'hAB,
              ex(1, 0, 0, 0, 0, 2'd0, 3'd0, 0, 32'h5, 32'h1234, 32'h0, 5'd3, 5'd1, 5'd2, 1));
        issue("lw_bypass", 0, 0, 32'h00812283, 32'h1C, 1, 5'd2, 32'h100,
              ex(1, 0, 0, 0, 1, 2'd1, 3'd0, 0, 32'h100, 32'h0, 32'h8, 5'd5, 5'd2, 5'd8, 1));
        issue("sw", 0, 0, 32'h00512623, 32'h20, 0, 5'd0, 32'h0,
              ex(0, 1, 0, 0, 1, 2'd0, 3'd0, 0, 32'h100, 32'hAB, 32'd12, 5'd12, 5'd2, 5'd5, 1));
        issue("beq", 0, 0, 32'h00208863, 32'h24, 0, 5'd0, 32'h0,
              ex(0, 0, 1, 0, 0, 2'd0, 3'd1, 0, 32'h5, 32'h100, 32'd16, 5'd16, 5'd1, 5'd2, 1));
        issue("jal", 0, 0, 32'hFF9FF0EF, 32'h28, 0, 5'd0, 32'h0,
              ex(1, 0, 0, 1, 0, 2'd2, 3'd0, 0, 32'h0, 32'h0, 32'hFFFFFFF8, 5'd1, 5'd31, 5'd25, 1));
        issue("flush", 0, 1, 32'h002081B3, 32'h2C, 1, 5'd6, 32'h77, ez());
        issue("after_flush_wb", 0, 0, 32'h00030433, 32'h30, 0, 5'd0, 32'h0,
              ex(1, 0, 0, 0, 0, 2'd0, 3'd0, 0, 32'h77, 32'h0, 32'h0, 5'd8, 5'd6, 5'd0, 1));
        issue("x0_wb", 0, 0, 32'h00000433, 32'h34, 1, 5'd0, 32'hFFFF,
              ex(1, 0, 0, 0, 0, 2'd0, 3'd0, 0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd0, 5'd0, 1));
        issue("slt", 0, 0, 32'h0020A533, 32'h38, 0, 5'd0, 32'h0,
              ex(1, 0, 0, 0, 0, 2'd0, 3'd5, 0, 32'h5, 32'h100, 32'h0, 5'd10, 5'd1, 5'd2, 1));
        issue("illegal", 0, 0, 32'h0000007F, 32'h3C, 0, 5'd0, 32'h0,
              ex(0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 0));
        issue("ori", 0, 0, 32'h0F00E593, 32'h40, 0, 5'd0, 32'h0,
              ex(1, 0, 0, 0, 1, 2'd0, 3'd3, 0, 32'h5, 32'h0, 32'hF0, 5'd11, 5'd1, 5'd16, 1));
        issue("andi_neg", 0, 0, 32'hFFF0F613, 32'h44, 0, 5'd0, 32'h0,
              ex(1, 0, 0, 0, 1, 2'd0, 3'd2, 0, 32'h5, 32'h0, 32'hFFFFFFFF, 5'd12, 5'd1, 5'd31, 1));
        issue("rst_mid", 1, 0, 32'h002081B3, 32'h48, 1, 5'd1, 32'h999, ez());
        issue("post_rst", 0, 0, 32'h002081B3, 32'h4C, 0, 5'd0, 32'h0,
              ex(1, 0, 0, 0, 0, 2'd0, 3'd0, 0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd1, 5'd2, 1));

        @(negedge clk);
        RegWriteW = 1'b0; FlushE = 1'b0; InstrD = 32'h0;
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        unused = chk("drain", "pending", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second stage of the five-stage RV32I pipeline: consumes the fetch stage's IF/ID outputs (InstrD, PCD, PCPlus4D) and produces the registered ID/EX bundle for the execute stage. It contains:
- the main/ALU control decoder;
- the immediate extender;
- the 32×32 register file, written back from the W stage;
- the ID/EX pipeline register, with flush-to-bubble.

## Interface
Parameters:
- XLEN, 32, datapath width.
- NREG, 32, architectural register count (x0 hardwired zero).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- InstrD  input  32  instruction from IF/ID.
- PCD  input  32  PC of InstrD.
- PCPlus4D  input  32  PCD+4.
- FlushE  input  1  load bubble into ID/EX this edge.
- RegWriteW  input  1  writeback enable.
- RDW  input  5  writeback destination.
- ResultW  input  32  writeback data.
- Rs1D, Rs2D  output  5  combinational source fields, for the hazard unit.
- RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE  output  1  registered control.
- ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  32  registered data.
- RdE, Rs1E, Rs2E  output  5  registered register fields.
- IllegalE  output  1  registered unsupported-opcode flag.

## Operation
- Supported opcodes:
  - 0000011 lw
  - 0100011 sw
  - 0110011 R-type (add/sub/and/or/slt)
  - 0010011 I-ALU (addi/andi/ori/slti)
  - 1100011 beq
  - 1101111 jal
- Any other opcode: all control outputs 0 and IllegalE=1; data fields are still registered.
- ALU decode:
  - lw, sw and jal force add.
  - beq forces sub.
  - R-type with funct7[5]=1 and funct3=000 gives sub.
  - I-ALU never gives sub.
- Immediate formats, sign-extended from bit 31:
  - I: InstrD[31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R-type: ImmExtD=0.
- Register file:
  - Written on rising edge when RegWriteW=1 and RDW≠0.
  - Reads of x0 always return 0.
- Write-through bypass: if RegWriteW=1, RDW≠0 and RDW equals a source field, the read value is ResultW in the same cycle. Same-cycle writeback is therefore visible in RD1E/RD2E one edge later.
- ID/EX register: on each edge, captures all decoded controls, RD1/RD2, ImmExt, Rd/Rs1/Rs2, PCD and PCPlus4D.
- Flush: with FlushE=1, all control bits, IllegalE and every ID/EX data/field output load 0 (bubble). The register-file write still occurs that edge.

## Timing
- Latency: InstrD at edge N → ID/EX outputs valid after edge N+1. No stall input; the ID/EX register loads every cycle.
- Reset: when rst=1 at an edge, all registered outputs go to 0 and all 32 registers go to 0.
- Reset priority: rst > FlushE > normal load.
- Reset mid-operation: any in-flight instruction is discarded, and the same-edge writeback is discarded too.
- Rs1D/Rs2D are purely combinational from InstrD[19:15]/[24:20] with no reset dependency.
- Simultaneous writeback and read of the same register: the new value is used (bypass).
- Simultaneous writeback to x0: no effect, and reads return 0.
- PCE and PCPlus4E are pass-through registers: no arithmetic, no wrap checking.

## Test plan
- **Reset:** hold rst=1 for 2 edges with InstrD=0x00500093 → all E outputs 0; any register read afterward returns 0.
- **I-ALU and bypass:**
  - InstrD=0x00500093 (addi x1,x0,5), PCD=0x10 → next edge: RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=5, RdE=1, RD1E=0, PCE=0x10, PCPlus4E=0x14.
  - Then RegWriteW=1, RDW=2, ResultW=0x1234 in the same cycle as InstrD=0x40118233 (sub x4,x3,x1) → ALUControlE=001.
  - Then InstrD=0x002081B3 (add x3,x1,x2) → RD2E=0x1234.
- **Memory:**
  - After x2=0x100 and x5=0xAB are written: InstrD=0x00812283 (lw x5,8(x2)) → ResultSrcE=01, ImmExtE=8, RD1E=0x100, MemWriteE=0.
  - InstrD=0x00512623 (sw x5,12(x2)) → MemWriteE=1, RegWriteE=0, ImmExtE=12, RD2E=0xAB.
- **Branch/jump:**
  - InstrD=0x00208863 (beq x1,x2,+16) → BranchE=1, ALUControlE=001, ImmExtE=16.
  - InstrD=0xFF9FF0EF (jal x1,-8) → JumpE=1, ResultSrcE=10, ImmExtE=0xFFFFFFF8.
- **Flush and x0:**
  - FlushE=1 with a valid add → all control 0, RdE=0, IllegalE=0.
  - RegWriteW=1, RDW=0, ResultW=0xFFFF → a read of x0 gives 0.
- **Illegal:** InstrD=0x0000007F → IllegalE=1, RegWriteE=MemWriteE=BranchE=JumpE=0.
